// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce_edge conditioner.
// State encodings: bit 1 is the settled level.
package debounce_pkg;

  typedef logic [1:0] state_t;

  localparam state_t STABLE_LO = 2'b00;
  localparam state_t QUAL_HI   = 2'b01;
  localparam state_t STABLE_HI = 2'b10;
  localparam state_t QUAL_LO   = 2'b11;

  function automatic state_t rst_state(input logic lvl);
    return lvl ? STABLE_HI : STABLE_LO;
  endfunction

endpackage

// File: rtl/debounce_edge_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear takes priority over a simultaneous increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // count up on inc, hold at all-ones, clear wins
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/debounce_edge.sv
// Debouncer for a synchronised control line: qualifies new
// levels over N clocks, emits edge strobes, counts glitches.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int   CNT_WIDTH   = 16,
  parameter logic RESET_LEVEL = 1'b0,
  parameter int   GCNT_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  sig_in,
  input  logic [CNT_WIDTH-1:0]  hold_cycles,
  input  logic                  clear_count,
  output logic                  level_out,
  output logic                  rise,
  output logic                  fall,
  output logic                  glitch,
  output logic [GCNT_WIDTH-1:0] glitch_count
);

  localparam state_t RST_STATE = rst_state(RESET_LEVEL);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic                 glitch_q, glitch_d;

  logic [CNT_WIDTH-1:0] n_eff;
  logic [CNT_WIDTH:0]   cnt_nx;
  logic                 n_one;
  logic                 done;

  // hold_cycles of zero behaves as one
  assign n_eff  = (hold_cycles == '0) ? CNT_WIDTH'(1)
                                      : hold_cycles;
  assign n_one  = (n_eff == CNT_WIDTH'(1));
  // one extra bit so the compare can never wrap
  assign cnt_nx = {1'b0, cnt_q} + (CNT_WIDTH+1)'(1);
  assign done   = (cnt_nx >= {1'b0, n_eff});

  // state, qualification counter and output registers
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q  <= RST_STATE;
      cnt_q    <= '0;
      level_q  <= RESET_LEVEL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  // next-state, counter and strobe decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        if (sig_in) begin
          if (n_one) begin
            state_d = STABLE_HI;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            state_d = QUAL_HI;
            cnt_d   = CNT_WIDTH'(1);
          end
        end
      end
      QUAL_HI: begin
        if (!sig_in) begin
          state_d  = STABLE_LO;
          cnt_d    = '0;
          glitch_d = 1'b1;
        end else if (done) begin
          state_d = STABLE_HI;
          level_d = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_nx[CNT_WIDTH-1:0];
        end
      end
      STABLE_HI: begin
        if (!sig_in) begin
          if (n_one) begin
            state_d = STABLE_LO;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            state_d = QUAL_LO;
            cnt_d   = CNT_WIDTH'(1);
          end
        end
      end
      QUAL_LO: begin
        if (sig_in) begin
          state_d  = STABLE_HI;
          cnt_d    = '0;
          glitch_d = 1'b1;
        end else if (done) begin
          state_d = STABLE_LO;
          level_d = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_nx[CNT_WIDTH-1:0];
        end
      end
      default: begin
        state_d = RST_STATE;
        cnt_d   = '0;
        level_d = RESET_LEVEL;
      end
    endcase
  end

  sat_counter #(
    .WIDTH (GCNT_WIDTH)
  ) u_gcnt (
    .clock (clock),
    .rst   (rst),
    .inc   (glitch_d),
    .clr   (clear_count),
    .count (glitch_count)
  );

  assign level_out = level_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign glitch    = glitch_q;

endmodule

// File: doc/debounce_edge.md
# debounce_edge

Destination-domain conditioner for a single external control line, such as a PTT, key or band-select strap, after it has passed a 2-flop synchroniser. It accepts a new level only after the level has held for a programmable number of consecutive clocks. It then publishes a stable level plus single-cycle rise and fall strobes, and counts rejected glitches for diagnostics. It sits directly downstream of the synchroniser and upstream of control/protocol logic.

## Interface
- CNT_WIDTH, 16: width of the qualification counter and of `hold_cycles`.
- RESET_LEVEL, 1'b0: level assumed for `level_out` and the FSM after reset.
- GCNT_WIDTH, 8: width of the saturating glitch counter.

Ports:
- clock  in  1  sole clock; every register is in this domain.
- rst  in  1  asynchronous, active-high reset.
- sig_in  in  1  already-synchronised input level; sampled every clock.
- hold_cycles  in  CNT_WIDTH  qualification length N = max(hold_cycles,1); quasi-static, read live every cycle.
- clear_count  in  1  synchronous clear of `glitch_count`.
- level_out  out  1  debounced level (registered).
- rise  out  1  one-clock strobe when `level_out` goes 0→1.
- fall  out  1  one-clock strobe when `level_out` goes 1→0.
- glitch  out  1  one-clock strobe when a qualification is aborted.
- glitch_count  out  GCNT_WIDTH  saturating count of glitch strobes.

## Operation
- FSM states:
  - STABLE_LO and STABLE_HI: settled level.
  - QUAL_HI and QUAL_LO: candidate new level.
  - Reset state is STABLE_HI if RESET_LEVEL else STABLE_LO.
- Qualification counter `cnt`, CNT_WIDTH bits, reset 0.
- STABLE_LO:
  - sig_in=0: stay.
  - sig_in=1 and N==1: go to STABLE_HI; `level_out`<=1, `rise`<=1.
  - sig_in=1 and N>1: go to QUAL_HI; `cnt`<=1.
- QUAL_HI:
  - sig_in=0: go to STABLE_LO; `cnt`<=0, `glitch`<=1.
  - sig_in=1 and `cnt`+1 >= N: go to STABLE_HI; `level_out`<=1, `rise`<=1, `cnt`<=0.
  - Otherwise: `cnt`<=`cnt`+1.
- STABLE_HI and QUAL_LO mirror the above with levels inverted; a completed qualification asserts `fall`.
- `cnt` never wraps. The `>=` compare means that if `hold_cycles` is lowered below `cnt` mid-qualification, the transition occurs on the next sample at the candidate level.
- glitch_count:
  - Increments on each `glitch` pulse.
  - Saturates at all-ones.
  - `clear_count` wins over a simultaneous increment; result 0.
- At most one of `rise`, `fall`, `glitch` is high in any cycle.

## Timing
- Reset values: `level_out`=RESET_LEVEL; `rise`=`fall`=`glitch`=0; `glitch_count`=0; `cnt`=0.
- Reset acts immediately on assertion, including mid-qualification; any partial qualification is discarded.
- Latency: if sig_in takes the new level at sampling edge k and holds it, `level_out` and the strobe update at edge k+N-1 and are visible during the following cycle. For N=1 this is the same edge k.
- End-to-end from the pin, add the synchroniser's 2 clocks.
- The strobe is coincident with the `level_out` change and lasts exactly 1 clock.
- `glitch` and the `glitch_count` increment take effect on the same edge; the count is visible one cycle after the glitch-causing sample.
- No handshake; the outputs are level/strobe only, and consumers must sample every clock.

## Structure
- Shared package `debounce_pkg`: 2-bit state encodings (STABLE_LO=2'b00, QUAL_HI=2'b01, STABLE_HI=2'b10, QUAL_LO=2'b11) as localparams. Bit 1 doubles as the settled-level indication.
- One natural sub-module, `sat_counter` (parameter WIDTH; ports `inc`, `clr`, `count`), reused for `glitch_count`.
- The FSM, qualification counter and output registers stay in `debounce_edge`.

## Test plan
- Reset release, RESET_LEVEL=0, hold_cycles=4; sig_in high for 4 clocks:
  - All outputs are 0 during reset.
  - `level_out`=1 after the 4th sampling edge.
  - `rise` is high for exactly 1 clock; `fall` and `glitch` stay 0.
- hold_cycles=4; sig_in high 3 clocks then low:
  - `level_out` stays 0.
  - `glitch` pulses once.
  - `glitch_count`=1.
- hold_cycles=0 and then 1; 1-clock high pulse:
  - Accepted on that edge, with `rise` asserted.
  - A following 1-clock low pulse gives `fall`.
- 300 back-to-back glitches at hold_cycles=8:
  - `glitch_count` saturates at 255.
  - `clear_count` asserted in the same cycle as a glitch gives `glitch_count`=0.
- hold_cycles=10 with `cnt`=5 in QUAL_HI; hold_cycles changed to 2 → `level_out` rises on the next high sample.
- `rst` asserted mid-QUAL_HI (`cnt`=3, hold_cycles=6):
  - Outputs return to reset values asynchronously.
  - After release, a full 6 high samples are needed before `rise`.
